regwr_arbiter: RTL and testbench

Arbitrates the register file's single write port among three requesters: core writeback (0), I2C controller status/data return (1) and host/debug loader (2). Selection is round-robin, with an optional lock that lets one requester own the port for a multi-word burst, such as loading all eight PWM registers back-to-back. Outputs are registered and drive the register file's write enable, write address and write data directly.

---
 rtl/regwr_arb_pkg.sv | 23 ++
 rtl/regwr_arbiter_rr_pick3.sv | 33 +++
 rtl/regwr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_regwr_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regwr_arb_pkg.sv
// rtl/regwr_arb_pkg.sv - shared ids, constants and state type for the register write-port arbiter
package regwr_arb_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_CORE = 2'd0;
  localparam logic [1:0] REQ_I2C  = 2'd1;
  localparam logic [1:0] REQ_HOST = 2'd2;

  localparam logic [3:0] REG_ZERO_ADDR = 4'd0;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Id 3 never names a requester, so it folds onto 0.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    case (id)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/regwr_arbiter_rr_pick3.sv
// rtl/regwr_arbiter_rr_pick3.sv - combinational rotating-priority picker over three requesters
module rr_pick3
  import regwr_arb_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic [1:0] grant_id
);

  logic [1:0] first_id;
  logic [1:0] second_id;
  logic [1:0] third_id;

  always_comb begin
    first_id  = (ptr == 2'd3) ? REQ_CORE : ptr;
    second_id = next_id(first_id);
    third_id  = next_id(second_id);
    grant     = '0;
    grant_id  = REQ_CORE;
    if (valid[first_id]) begin
      grant_id = first_id;
    end else if (valid[second_id]) begin
      grant_id = second_id;
    end else if (valid[third_id]) begin
      grant_id = third_id;
    end
    if (|valid) begin
      grant = 3'b001 << grant_id;
    end
  end

endmodule

// File: rtl/regwr_arbiter.sv
// rtl/regwr_arbiter.sv - register-file write-port arbiter, round-robin with burst lock and lock timeout
// Optional REGWR_ARB_CORE_PRIO_EN: core requester wins outright in IDLE, 1/2 round-robin.
module regwr_arbiter
  import regwr_arb_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_lock,
  input  logic [4*NUM_REQ-1:0]   req_addr,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   write_en,
  output logic [3:0]             wr_addr,
  output logic [15:0]            wr_data,
  output logic [1:0]             grant_id,
  output logic                   locked,
  output logic                   lock_timeout
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(LOCK_TIMEOUT - 1);

  arb_state_t state, state_nxt;
  logic [1:0] owner, owner_nxt;
  logic [1:0] rr_ptr, rr_nxt;
  logic [7:0] idle_cnt, cnt_nxt;
  logic [2:0] pick_valid, pick_grant;
  logic [1:0] pick_id, win_id;
  logic       xfer, timeout_nxt;
  logic [3:0] win_addr;
  logic [15:0] win_data;

  function automatic logic [1:0] rr_after(input logic [1:0] id);
`ifdef REGWR_ARB_CORE_PRIO_EN
    return (id == REQ_I2C) ? REQ_HOST : REQ_I2C;
`else
    return next_id(id);
`endif
  endfunction

`ifdef REGWR_ARB_CORE_PRIO_EN
  assign pick_valid = {req_valid[2:1], 1'b0};
`else
  assign pick_valid = req_valid;
`endif

  rr_pick3 u_pick (
    .valid    (pick_valid),
    .ptr      (rr_ptr),
    .grant    (pick_grant),
    .grant_id (pick_id)
  );

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_nxt      = rr_ptr;
    cnt_nxt     = idle_cnt;
    req_ready   = '0;
    xfer        = 1'b0;
    win_id      = owner;
    timeout_nxt = 1'b0;
    case (state)
      ARB_IDLE: begin
`ifdef REGWR_ARB_CORE_PRIO_EN
        if (req_valid[0]) begin
          win_id    = REQ_CORE;
          req_ready = 3'b001;
        end else begin
          win_id    = pick_id;
          req_ready = pick_grant;
        end
        xfer = |req_ready;
        if (xfer && win_id != REQ_CORE) begin
          rr_nxt = rr_after(win_id);
        end
`else
        win_id    = pick_id;
        req_ready = pick_grant;
        xfer      = |req_ready;
        if (xfer) begin
          rr_nxt = rr_after(win_id);
        end
`endif
        if (xfer && req_lock[win_id]) begin
          state_nxt = ARB_LOCKED;
          owner_nxt = win_id;
          cnt_nxt   = '0;
        end
      end
      ARB_LOCKED: begin
        if (req_valid[owner]) begin
          req_ready = 3'b001 << owner;
          xfer      = 1'b1;
          cnt_nxt   = '0;
          if (!req_lock[owner]) begin
            state_nxt = ARB_IDLE;
            rr_nxt    = rr_after(owner);
          end
        end else if (idle_cnt >= TIMEOUT_LAST) begin
          // Owner went quiet too long; reclaim the port without issuing a write.
          state_nxt   = ARB_IDLE;
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          rr_nxt      = rr_after(owner);
        end else begin
          cnt_nxt = idle_cnt + 8'd1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (rst) begin
      req_ready = '0;
    end
  end

  always_comb begin
    case (win_id)
      2'd1: begin
        win_addr = req_addr[7:4];
        win_data = req_data[31:16];
      end
      2'd2: begin
        win_addr = req_addr[11:8];
        win_data = req_data[47:32];
      end
      default: begin
        win_addr = req_addr[3:0];
        win_data = req_data[15:0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      owner        <= REQ_CORE;
      rr_ptr       <= '0;
      idle_cnt     <= '0;
      write_en     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      grant_id     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      rr_ptr       <= rr_nxt;
      idle_cnt     <= cnt_nxt;
      lock_timeout <= timeout_nxt;
      // Address 0 is hard-wired zero: handshake completes but nothing is written.
      write_en     <= xfer && (win_addr != REG_ZERO_ADDR);
      if (xfer) begin
        wr_addr  <= win_addr;
        wr_data  <= win_data;
        grant_id <= win_id;
      end
    end
  end

  assign locked = (state == ARB_LOCKED);

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb/tb_regwr_arbiter.sv - randomized scoreboard bench for regwr_arbiter against a behavioural model
module tb_regwr_arbiter;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid, req_lock, req_ready;
  logic [11:0] req_addr;
  logic [47:0] req_data;
  logic        write_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  grant_id;
  logic        locked, lock_timeout;

  regwr_arbiter #(.LOCK_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_en     (write_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .grant_id     (grant_id),
    .locked       (locked),
    .lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [1:0]  gid;
    logic        lk;
    logic        to;
  } out_t;

  out_t       exp_out_q[$];
  logic [2:0] exp_rdy_q[$];
  int         compared = 0;
  int         mismatched = 0;
  bit         mon_en = 1'b0;

  // Pending request per requester; held stable until it is transferred.
  bit          pv[3];
  bit          pl[3];
  logic [3:0]  pa[3];
  logic [15:0] pd[3];

  int   m_ptr, m_owner, m_idle;
  out_t m_out;
  int   n_timeout = 0, n_zero = 0, n_release = 0, n_burst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input int w);
`ifdef REGWR_ARB_CORE_PRIO_EN
    return (w == 1) ? 2 : 1;
`else
    return (w + 1) % 3;
`endif
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_idle  = 0;
    m_out   = '0;
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
  endtask

  task automatic take(input int w);
    m_out.we   = (pa[w] != 4'd0);
    m_out.addr = pa[w];
    m_out.data = pd[w];
    m_out.gid  = 2'(w);
    if (pa[w] == 4'd0) n_zero++;
    pv[w] = 1'b0;
  endtask

  task automatic model_step(output logic [2:0] rdy);
    int w;
    bit lk;
    w = -1;
    rdy = '0;
    m_out.we = 1'b0;
    m_out.to = 1'b0;
    if (m_owner < 0) begin
`ifdef REGWR_ARB_CORE_PRIO_EN
      if (pv[0]) w = 0;
      else begin
        int order[2];
        order = (m_ptr == 2) ? '{2, 1} : '{1, 2};
        for (int k = 0; k < 2; k++) if (w < 0 && pv[order[k]]) w = order[k];
      end
`else
      for (int k = 0; k < 3; k++) if (w < 0 && pv[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
`endif
      if (w >= 0) begin
        rdy = 3'(1 << w);
        lk  = pl[w];
        take(w);
`ifdef REGWR_ARB_CORE_PRIO_EN
        if (w != 0) m_ptr = rr_next(w);
`else
        m_ptr = rr_next(w);
`endif
        if (lk) begin
          m_owner = w;
          m_idle  = 0;
          n_burst++;
        end
      end
    end else begin
      if (pv[m_owner]) begin
        w   = m_owner;
        rdy = 3'(1 << w);
        lk  = pl[w];
        take(w);
        m_idle = 0;
        if (!lk) begin
          m_ptr   = rr_next(w);
          m_owner = -1;
          n_release++;
        end
      end else begin
        m_idle++;
        if (m_idle == T) begin
          m_out.to = 1'b1;
          m_ptr    = rr_next(m_owner);
          m_owner  = -1;
          m_idle   = 0;
          n_timeout++;
        end
      end
    end
    m_out.lk = (m_owner >= 0);
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      req_valid[i]           = pv[i];
      req_lock[i]            = pl[i];
      req_addr[i*4 +: 4]     = pa[i];
      req_data[i*16 +: 16]   = pd[i];
    end
  endtask

  task automatic step_body();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) begin
      if (!pv[i] && $urandom_range(0, 99) < 35) begin
        pv[i] = 1'b1;
        pl[i] = ($urandom_range(0, 99) < 40);
        pa[i] = 4'($urandom_range(0, 15));
        pd[i] = 16'($urandom);
      end
    end
    drive();
    #1;
    model_step(r);
    exp_rdy_q.push_back(r);
    exp_out_q.push_back(m_out);
    mon_en = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      step_body();
    end
  endtask

  // Monitor: pops expectations and compares whatever the DUT presents.
  out_t       mo;
  logic [2:0] mr;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (exp_rdy_q.size() == 0) check("rdy_queue_empty", 32'd0, 32'd1);
        else begin
          mr = exp_rdy_q.pop_front();
          check("req_ready", {29'd0, req_ready}, {29'd0, mr});
        end
      end
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_out_q.size() == 0) check("out_queue_empty", 32'd0, 32'd1);
        else begin
          mo = exp_out_q.pop_front();
          check("write_en", {31'd0, write_en}, {31'd0, mo.we});
          check("wr_addr", {28'd0, wr_addr}, {28'd0, mo.addr});
          check("wr_data", {16'd0, wr_data}, {16'd0, mo.data});
          check("grant_id", {30'd0, grant_id}, {30'd0, mo.gid});
          check("locked", {31'd0, locked}, {31'd0, mo.lk});
          check("lock_timeout", {31'd0, lock_timeout}, {31'd0, mo.to});
        end
      end
    end
  end

  initial begin
    bit found;
    model_reset();
    req_valid = 3'b111;
    req_lock  = 3'b111;
    req_addr  = 12'h321;
    req_data  = 48'h3333_2222_1111;
    #12;
    check("rst_write_en", {31'd0, write_en}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_lock_timeout", {31'd0, lock_timeout}, 32'd0);
    check("rst_req_ready", {29'd0, req_ready}, 32'd0);
    drive();
    @(negedge clk);
    rst = 1'b0;
    run_cycles(600);

    // Asynchronous reset landing mid-cycle while a write strobe is up.
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (write_en) found = 1'b1;
      else step_body();
    end
    mon_en = 1'b0;
    check("found_write_for_reset", {31'd0, found}, 32'd1);
    for (int i = 0; i < 3; i++) pv[i] = 1'b1;
    drive();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_write_en", {31'd0, write_en}, 32'd0);
    check("async_rst_locked", {31'd0, locked}, 32'd0);
    check("async_rst_req_ready", {29'd0, req_ready}, 32'd0);
    exp_out_q.delete();
    exp_rdy_q.delete();
    model_reset();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_cycles(600);

    @(posedge clk);
    #3;
    check("queues_drained", 32'(exp_out_q.size() + exp_rdy_q.size()), 32'd0);
    check("saw_timeout", {31'd0, n_timeout > 0}, 32'd1);
    check("saw_zero_addr", {31'd0, n_zero > 0}, 32'd1);
    check("saw_lock_release", {31'd0, n_release > 0}, 32'd1);
    check("saw_burst", {31'd0, n_burst > 0}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
